// File: rtl/key_pkg.sv
// Shared types and 50 MHz default timing for the key step counter.
// Optional buzzer feature (top level) is enabled by defining KEY_STEP_COUNTER_BEEP_EN.
package key_pkg;

    // Per-key debounce / long-press state machine states
    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        REPEAT,
        REL_DB
    } key_state_t;

    // Key timers are wide enough for a multi-second hold at 50 MHz
    localparam int unsigned TMR_W = 32;

    // Default timing at 50 MHz
    localparam int unsigned DEF_DEBOUNCE_CYC = 1000000;  // 20 ms
    localparam int unsigned DEF_LONG_CYC     = 50000000; // 1 s
    localparam int unsigned DEF_REPEAT_CYC   = 10000000; // 200 ms
    localparam int unsigned DEF_BEEP_CYC     = 2500000;  // 50 ms
    localparam int unsigned DEF_BEEP_HALF    = 113636;   // 220 Hz half period

    // Terminal timer value for an interval of 'cyc' cycles (guards cyc == 0)
    function automatic logic [TMR_W-1:0] last_tick(input int unsigned cyc);
        return (cyc == 0) ? '0 : TMR_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/key_press_fsm.sv
// One push-button: 2-FF synchroniser, debounce, single step on press,
// auto-repeat after a long hold, debounced release.
module key_press_fsm
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
    parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic step
);

    localparam logic [TMR_W-1:0] DB_LAST   = last_tick(DEBOUNCE_CYC);
    localparam logic [TMR_W-1:0] LONG_LAST = last_tick(LONG_CYC);
    localparam logic [TMR_W-1:0] RPT_LAST  = last_tick(REPEAT_CYC);

    logic [1:0]       r_sync;
    logic             w_k;
    key_state_t       r_state;
    key_state_t       r_prev;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] r_rel;
    logic             r_step;

    // Two-stage synchroniser; idles at "released" so a held key after reset is a fresh press
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], i_key_n};
    end

    assign w_k  = ~r_sync[1];
    assign step = r_step;

    // Key FSM: r_timer tracks press/hold/repeat time, r_rel tracks release stability
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_prev  <= HELD;
            r_timer <= '0;
            r_rel   <= '0;
            r_step  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    r_rel   <= '0;
                    if (w_k) r_state <= DEBOUNCE;
                end
                DEBOUNCE: begin
                    if (!w_k) begin
                        r_state <= IDLE;
                    end else if (r_timer == DB_LAST) begin
                        r_state <= HELD;
                        r_timer <= '0;
                        r_step  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                HELD, REPEAT: begin
                    if (!w_k) begin
                        // timer is frozen while the release is being qualified
                        r_prev  <= r_state;
                        r_rel   <= '0;
                        r_state <= REL_DB;
                    end else if ((r_state == HELD   && r_timer == LONG_LAST) ||
                                 (r_state == REPEAT && r_timer == RPT_LAST)) begin
                        r_state <= REPEAT;
                        r_timer <= '0;
                        r_step  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                REL_DB: begin
                    // a release bounce resumes the hold without emitting a step
                    if (w_k) begin
                        r_state <= r_prev;
                    end else if (r_rel == DB_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_rel <= r_rel + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_step_counter.sv
// Up/down counter driven by two debounced active-low keys with auto-repeat.
// Define KEY_STEP_COUNTER_BEEP_EN to add the 'beep' buzzer output.
module key_step_counter
    import key_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
    parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter int unsigned SATURATE     = 1
`ifdef KEY_STEP_COUNTER_BEEP_EN
   ,parameter int unsigned BEEP_CYC     = DEF_BEEP_CYC,
    parameter int unsigned BEEP_HALF    = DEF_BEEP_HALF
`endif
) (
    input  logic             FPGA_CLK,
    input  logic             RESET_BUT,
    input  logic             KEY_INC_N,
    input  logic             KEY_DEC_N,
    output logic [WIDTH-1:0] count,
    output logic             step_pulse,
    output logic             at_max,
    output logic             at_min
`ifdef KEY_STEP_COUNTER_BEEP_EN
   ,output logic             beep
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [1:0]       r_rst_sync;
    logic             w_rst;
    logic             w_inc_step;
    logic             w_dec_step;
    logic             w_inc;
    logic             w_dec;
    logic             w_apply;
    logic             w_clamp;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_count;
    logic             r_step_pulse;
    logic             r_at_max;
    logic             r_at_min;

    // Reset asserts immediately, releases two clocks later in the FPGA_CLK domain
    always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
        if (RESET_BUT) r_rst_sync <= 2'b11;
        else           r_rst_sync <= {r_rst_sync[0], 1'b0};
    end

    assign w_rst = r_rst_sync[1];

    key_press_fsm #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .LONG_CYC     (LONG_CYC),
        .REPEAT_CYC   (REPEAT_CYC)
    ) u_key_inc (
        .i_clk   (FPGA_CLK),
        .i_rst   (w_rst),
        .i_key_n (KEY_INC_N),
        .step    (w_inc_step)
    );

    key_press_fsm #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .LONG_CYC     (LONG_CYC),
        .REPEAT_CYC   (REPEAT_CYC)
    ) u_key_dec (
        .i_clk   (FPGA_CLK),
        .i_rst   (w_rst),
        .i_key_n (KEY_DEC_N),
        .step    (w_dec_step)
    );

    // Coincident inc/dec events cancel; a clamped step still counts as applied
    always_comb begin
        w_inc   = w_inc_step & ~w_dec_step;
        w_dec   = w_dec_step & ~w_inc_step;
        w_apply = w_inc | w_dec;
        w_clamp = (SATURATE != 0) &&
                  ((w_inc && r_count == MAX_VAL) || (w_dec && r_count == '0));
        w_next  = r_count;
        if (!w_clamp) begin
            if (w_inc)      w_next = r_count + 1'b1;
            else if (w_dec) w_next = r_count - 1'b1;
        end
    end

    // Counter plus flags registered from the same next value so they never disagree
    always_ff @(posedge FPGA_CLK or posedge w_rst) begin
        if (w_rst) begin
            r_count      <= '0;
            r_step_pulse <= 1'b0;
            r_at_max     <= 1'b0;
            r_at_min     <= 1'b1;
        end else begin
            r_count      <= w_next;
            r_step_pulse <= w_apply;
            r_at_max     <= (w_next == MAX_VAL);
            r_at_min     <= (w_next == '0);
        end
    end

    assign count      = r_count;
    assign step_pulse = r_step_pulse;
    assign at_max     = r_at_max;
    assign at_min     = r_at_min;

`ifdef KEY_STEP_COUNTER_BEEP_EN
    localparam logic [31:0] BEEP_LEN  = 32'(BEEP_CYC);
    localparam logic [31:0] BEEP_LEN2 = 32'(2 * BEEP_CYC);
    localparam logic [31:0] HALF_LAST = (BEEP_HALF == 0) ? 32'd0 : 32'(BEEP_HALF - 1);

    logic [31:0] r_beep_cnt;
    logic [31:0] r_half_cnt;
    logic        r_beep;

    // Burst timer and tone divider; a clamped step gets a double-length warning burst
    always_ff @(posedge FPGA_CLK or posedge w_rst) begin
        if (w_rst) begin
            r_beep_cnt <= '0;
            r_half_cnt <= '0;
            r_beep     <= 1'b0;
        end else if (w_apply) begin
            r_beep_cnt <= w_clamp ? BEEP_LEN2 : BEEP_LEN;
            r_half_cnt <= '0;
            r_beep     <= 1'b1;
        end else if (r_beep_cnt != '0) begin
            r_beep_cnt <= r_beep_cnt - 1'b1;
            if (r_beep_cnt == 32'd1) begin
                r_beep <= 1'b0;
            end else if (r_half_cnt == HALF_LAST) begin
                r_half_cnt <= '0;
                r_beep     <= ~r_beep;
            end else begin
                r_half_cnt <= r_half_cnt + 1'b1;
            end
        end
    end

    assign beep = r_beep;
`endif

endmodule

// File: doc/key_step_counter.md
Name: key_step_counter

Overview:
Parametrised up/down counter driven by two active-low board push-buttons (INC, DEC).
- Synchronises and debounces each key.
- Emits one step on each confirmed press, then auto-repeats steps while the key is held past a long-press threshold.
- Saturates or wraps at the range limits.
- Sits between the raw KEYx pins and display logic (LEDs, 7-seg), replacing edge-clocked key logic with a single FPGA_CLK domain.

Parameters:
- WIDTH, 4, counter width in bits.
- DEBOUNCE_CYC, 1000000, cycles a key must be stable before a change is accepted (20 ms at 50 MHz).
- LONG_CYC, 50000000, cycles a key must be held, counted from the accepted press, before auto-repeat starts (1 s).
- REPEAT_CYC, 10000000, cycles between auto-repeat steps (200 ms).
- SATURATE, 1, 1 = clamp at 0 / 2^WIDTH-1; 0 = modulo wrap.
- BEEP_CYC, 2500000, beep burst length in cycles (50 ms); used only with the optional feature.
- BEEP_HALF, 113636, beep tone half-period in cycles (220 Hz); used only with the optional feature.

Ports:
- FPGA_CLK, in, 1, system clock, 50 MHz.
- RESET_BUT, in, 1, asynchronous reset, active-high.
- KEY_INC_N, in, 1, increment key, active-low, asynchronous to the clock.
- KEY_DEC_N, in, 1, decrement key, active-low, asynchronous to the clock.
- count, out, WIDTH, current counter value.
- step_pulse, out, 1, one-cycle pulse on every applied step, including clamped steps.
- at_max, out, 1, count == 2^WIDTH-1.
- at_min, out, 1, count == 0.
- beep, out, 1, buzzer drive; present only with the optional feature.

Behaviour:
- Reset: async assert, sync deassert in the user's domain.
  - count = 0, step_pulse = 0, at_max = 0, at_min = 1, beep = 0.
  - All key FSMs go to IDLE; all timers clear.
  - Reset mid-hold: after release of reset, a key still held is treated as a fresh press and goes through DEBOUNCE again.
- Input sync: 2-FF synchroniser per key, inverted to active-high `k`. This adds 2 cycles of latency.
- Per-key FSM, 16..32-bit timer:
  - IDLE: k=1 → DEBOUNCE; timer clears.
  - DEBOUNCE: k=0 → IDLE. Timer reaches DEBOUNCE_CYC-1 with k=1 → HELD, and a step event is issued on the transition cycle.
  - HELD: k=0 → REL_DB. Timer reaches LONG_CYC-1 → REPEAT, with a step event.
  - REPEAT: k=0 → REL_DB. Every REPEAT_CYC cycles a step event is issued.
  - REL_DB: k=1 → previous state (HELD or REPEAT), timer preserved. k=0 stable for DEBOUNCE_CYC → IDLE. A bounce on release therefore never generates a step.
- Step latency: count updates on the cycle after the step event. step_pulse is high in that same cycle.
- Arithmetic:
  - inc only → count+1; dec only → count-1.
  - Inc and dec events in the same cycle cancel: no change, no step_pulse.
  - SATURATE=1: inc at max or dec at 0 leaves count unchanged; step_pulse still fires.
  - SATURATE=0: wraps modulo 2^WIDTH, e.g. max+1 → 0 and 0-1 → max.
- at_max and at_min are registered and always consistent with count.
- Both keys held together: each key's FSM runs independently. Repeats cancel only on coincident cycles; otherwise they interleave.

Optional Feature:
- Macro: KEY_STEP_COUNTER_BEEP_EN.
- Defined:
  - Port beep exists.
  - Each step_pulse (re)starts a BEEP_CYC burst of a square wave toggling every BEEP_HALF cycles. A new step during a burst restarts its length.
  - A clamped step (saturated, no count change) produces a double-length burst as a limit warning.
  - beep = 0 outside bursts.
- Undefined: no beep port, no beep logic.

Decomposition:
- Shared package key_pkg holds:
  - key FSM state enum: IDLE, DEBOUNCE, HELD, REPEAT, REL_DB;
  - default timing constants at 50 MHz: DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC, BEEP_HALF.
- Sub-module key_press_fsm:
  - contains the synchroniser, FSM and timer;
  - port `step` is a one-cycle event;
  - instantiated twice.
- Counter, flags and beep logic live in the top.

Test Plan:
Use DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5, WIDTH=4 throughout.
1. Reset with a key held: assert RESET_BUT mid-hold → count=0, at_min=1, step_pulse=0. After release, exactly one step follows after 2+4 cycles.
2. INC bouncing 1-0-1 with 2-cycle pulses, then stable low for 10 cycles and released → exactly one step, count=1. Release bounce → no extra step.
3. INC held 40 cycles → steps at debounce, +20, +25, +30, +35, giving count=5.
4. SATURATE=1, count=15, INC press → count stays 15, step_pulse=1, at_max=1. SATURATE=0, same stimulus → count=0, at_min=1.
5. INC and DEC confirmed in the same cycle → count unchanged, no step_pulse. Offset the confirmations by 1 cycle → +1 then -1, two step_pulses.
6. With KEY_STEP_COUNTER_BEEP_EN and BEEP_CYC=8, BEEP_HALF=2: one step → beep toggles every 2 cycles for 8 cycles. A clamped step → 16 cycles.
